cpu64_l2_victim_alloc: RTL and testbench

CPU64_L2_VICTIM_ALLOC -- requirements
Module: cpu64_l2_victim_alloc

---
 rtl/cpu64_l2_victim_alloc.sv | 148 ++++++++++++++
 tb/tb_cpu64_l2_victim_alloc.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu64_l2_victim_alloc.sv
// Purpose : L2 miss victim allocator - picks a way per set, writes back dirty victims, grants the way.
// Latency : clean victim alloc_valid_o 2 cycles after accept; dirty victim adds WB handshake + wb_done_i.
// Backpress: one request in flight; req_ready_o only in IDLE; wb/alloc outputs hold until their ready.
//
// Ports:
//   clk_i, rst_ni                      single clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_set_i  miss-allocation request
//   meta_set_o, meta_valid_i/dirty_i   set index to tag/meta array (and PLRU), combinational meta bits back
//   plru_valid_o, plru_victim_i        valid bits forwarded to PLRU, victim way returned
//   plru_access_o, plru_way_o          PLRU touch pulse on the grant handshake
//   wb_*                               writeback request handshake plus wb_done_i completion pulse
//   alloc_*                            allocation result handshake

module cpu64_l2_victim_alloc #(
    parameter  int SET_W = 8,
    parameter  int WAYS  = 16,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [SET_W-1:0] req_set_i,

    output logic [SET_W-1:0] meta_set_o,
    input  logic [WAYS-1:0]  meta_valid_i,
    input  logic [WAYS-1:0]  meta_dirty_i,

    output logic [WAYS-1:0]  plru_valid_o,
    input  logic [WAY_W-1:0] plru_victim_i,
    output logic             plru_access_o,
    output logic [WAY_W-1:0] plru_way_o,

    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [SET_W-1:0] wb_set_o,
    output logic [WAY_W-1:0] wb_way_o,
    input  logic             wb_done_i,

    output logic             alloc_valid_o,
    input  logic             alloc_ready_i,
    output logic [SET_W-1:0] alloc_set_o,
    output logic [WAY_W-1:0] alloc_way_o,
    output logic             alloc_evict_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_WB_REQ  = 3'd2;
    localparam logic [2:0] S_WB_WAIT = 3'd3;
    localparam logic [2:0] S_GRANT   = 3'd4;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [SET_W-1:0] set_q;
    logic [WAY_W-1:0] way_q;
    logic             evict_q;

    logic             req_fire;
    logic             wb_fire;
    logic             alloc_fire;
    logic             victim_evict;

    assign req_fire   = (state_q == S_IDLE)  && req_valid_i;
    assign wb_fire    = (state_q == S_WB_REQ) && wb_ready_i;
    assign alloc_fire = (state_q == S_GRANT) && alloc_ready_i;

    // The meta array sees the set register during LOOKUP, so the bits indexed
    // by the PLRU victim are exactly those of the way being latched. Only a
    // line that is both valid and dirty needs writing back; an invalid way's
    // dirty bit is stale and ignored.
    assign victim_evict = meta_valid_i[plru_victim_i] & meta_dirty_i[plru_victim_i];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = victim_evict ? S_WB_REQ : S_GRANT;
            end
            S_WB_REQ: begin
                if (wb_ready_i) begin
                    state_d = S_WB_WAIT;
                end
            end
            S_WB_WAIT: begin
                if (wb_done_i) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (alloc_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            way_q   <= '0;
            evict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                set_q <= req_set_i;
            end
            if (state_q == S_LOOKUP) begin
                way_q   <= plru_victim_i;
                evict_q <= victim_evict;
            end
        end
    end

    // In IDLE the incoming set is passed straight through so the meta array
    // and PLRU can start their lookup in the accept cycle.
    assign meta_set_o    = (state_q == S_IDLE) ? req_set_i : set_q;
    assign req_ready_o   = (state_q == S_IDLE);

    assign plru_valid_o  = meta_valid_i;
    assign plru_access_o = alloc_fire;
    assign plru_way_o    = way_q;

    assign wb_valid_o    = (state_q == S_WB_REQ);
    assign wb_set_o      = set_q;
    assign wb_way_o      = way_q;

    assign alloc_valid_o = (state_q == S_GRANT);
    assign alloc_set_o   = set_q;
    assign alloc_way_o   = way_q;
    assign alloc_evict_o = evict_q;

    // wb_fire documents the WB_REQ handshake; the transition itself lives in
    // the next-state logic, so keep it referenced for readability only.
    logic unused_wb_fire;
    assign unused_wb_fire = wb_fire;

endmodule

// File: tb/tb_cpu64_l2_victim_alloc.sv
module tb_cpu64_l2_victim_alloc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_set_i;
    logic [7:0]  meta_set_o;
    logic [15:0] meta_valid_i;
    logic [15:0] meta_dirty_i;
    logic [15:0] plru_valid_o;
    logic [3:0]  plru_victim_i;
    logic        plru_access_o;
    logic [3:0]  plru_way_o;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [7:0]  wb_set_o;
    logic [3:0]  wb_way_o;
    logic        wb_done_i;
    logic        alloc_valid_o;
    logic        alloc_ready_i;
    logic [7:0]  alloc_set_o;
    logic [3:0]  alloc_way_o;
    logic        alloc_evict_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    cpu64_l2_victim_alloc #(.SET_W(8), .WAYS(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
        .meta_set_o(meta_set_o), .meta_valid_i(meta_valid_i), .meta_dirty_i(meta_dirty_i),
        .plru_valid_o(plru_valid_o), .plru_victim_i(plru_victim_i),
        .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o),
        .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
        .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i), .alloc_set_o(alloc_set_o),
        .alloc_way_o(alloc_way_o), .alloc_evict_o(alloc_evict_o)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_alloc_valid: got %b want 0", alloc_valid_o); end
        n_cmp++; if (plru_access_o !== 1'b0) begin n_err++; $display("FAIL rst_plru_access: got %b want 0", plru_access_o); end
        n_cmp++; if (alloc_way_o !== 4'd0) begin n_err++; $display("FAIL rst_alloc_way: got %0d want 0", alloc_way_o); end
        n_cmp++; if (alloc_set_o !== 8'h00) begin n_err++; $display("FAIL rst_alloc_set: got %h want 00", alloc_set_o); end
        n_cmp++; if (alloc_evict_o !== 1'b0) begin n_err++; $display("FAIL rst_alloc_evict: got %b want 0", alloc_evict_o); end
        #4;
        rst_ni = 1'b1;
    endtask

    task automatic test_clean_victim();
        step();
        req_valid_i = 1'b1; req_set_i = 8'h12; meta_valid_i = 16'h00FF;
        meta_dirty_i = 16'h0000; plru_victim_i = 4'd8;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL clean_c0_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (meta_set_o !== 8'h12) begin n_err++; $display("FAIL clean_c0_meta_set: got %h want 12", meta_set_o); end
        n_cmp++; if (plru_valid_o !== 16'h00FF) begin n_err++; $display("FAIL clean_plru_valid: got %h want 00ff", plru_valid_o); end
        step();
        req_valid_i = 1'b0; req_set_i = 8'h77;
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL clean_c1_ready: got %b want 0", req_ready_o); end
        n_cmp++; if (meta_set_o !== 8'h12) begin n_err++; $display("FAIL clean_c1_meta_set: got %h want 12", meta_set_o); end
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL clean_c1_alloc_valid: got %b want 0", alloc_valid_o); end
        step();
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b1) begin n_err++; $display("FAIL clean_c2_alloc_valid: got %b want 1", alloc_valid_o); end
        n_cmp++; if (alloc_way_o !== 4'd8) begin n_err++; $display("FAIL clean_alloc_way: got %0d want 8", alloc_way_o); end
        n_cmp++; if (alloc_evict_o !== 1'b0) begin n_err++; $display("FAIL clean_alloc_evict: got %b want 0", alloc_evict_o); end
        n_cmp++; if (alloc_set_o !== 8'h12) begin n_err++; $display("FAIL clean_alloc_set: got %h want 12", alloc_set_o); end
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL clean_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (plru_access_o !== 1'b0) begin n_err++; $display("FAIL clean_access_early: got %b want 0", plru_access_o); end
        alloc_ready_i = 1'b1;
        #1;
        n_cmp++; if (plru_access_o !== 1'b1) begin n_err++; $display("FAIL clean_access: got %b want 1", plru_access_o); end
        n_cmp++; if (plru_way_o !== 4'd8) begin n_err++; $display("FAIL clean_plru_way: got %0d want 8", plru_way_o); end
        step();
        alloc_ready_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL clean_c3_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (plru_access_o !== 1'b0) begin n_err++; $display("FAIL clean_c3_access: got %b want 0", plru_access_o); end
    endtask

    task automatic test_dirty_writeback();
        step();
        req_valid_i = 1'b1; req_set_i = 8'h34; meta_valid_i = 16'hFFFF;
        meta_dirty_i = 16'h0020; plru_victim_i = 4'd5;
        step();
        req_valid_i = 1'b0;
        step();
        // Victim inputs change after LOOKUP; the latched way must not follow.
        plru_victim_i = 4'd9; meta_dirty_i = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            wb_done_i = (i == 1);
            #1;
            n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL dirty_wb_valid[%0d]: got %b want 1", i, wb_valid_o); end
            n_cmp++; if (wb_way_o !== 4'd5) begin n_err++; $display("FAIL dirty_wb_way[%0d]: got %0d want 5", i, wb_way_o); end
            n_cmp++; if (wb_set_o !== 8'h34) begin n_err++; $display("FAIL dirty_wb_set[%0d]: got %h want 34", i, wb_set_o); end
            n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL dirty_alloc_early[%0d]: got %b want 0", i, alloc_valid_o); end
        end
        step();
        wb_done_i = 1'b0; wb_ready_i = 1'b1;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL dirty_wb_hs_valid: got %b want 1", wb_valid_o); end
        step();
        wb_ready_i = 1'b0;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL dirty_wait_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL dirty_wait_alloc: got %b want 0", alloc_valid_o); end
        step();
        wb_done_i = 1'b1;
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL dirty_done_alloc: got %b want 0", alloc_valid_o); end
        step();
        wb_done_i = 1'b0;
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b1) begin n_err++; $display("FAIL dirty_alloc_valid: got %b want 1", alloc_valid_o); end
        n_cmp++; if (alloc_way_o !== 4'd5) begin n_err++; $display("FAIL dirty_alloc_way: got %0d want 5", alloc_way_o); end
        n_cmp++; if (alloc_evict_o !== 1'b1) begin n_err++; $display("FAIL dirty_alloc_evict: got %b want 1", alloc_evict_o); end
        n_cmp++; if (alloc_set_o !== 8'h34) begin n_err++; $display("FAIL dirty_alloc_set: got %h want 34", alloc_set_o); end
        // Grant held with alloc_ready_i low for 4 cycles total.
        for (int i = 1; i < 4; i++) begin
            step();
            #1;
            n_cmp++; if (plru_access_o !== 1'b0) begin n_err++; $display("FAIL hold_access[%0d]: got %b want 0", i, plru_access_o); end
            n_cmp++; if (alloc_valid_o !== 1'b1 || alloc_way_o !== 4'd5 || alloc_evict_o !== 1'b1) begin
                n_err++; $display("FAIL hold_alloc[%0d]: got v=%b w=%0d e=%b want v=1 w=5 e=1", i, alloc_valid_o, alloc_way_o, alloc_evict_o);
            end
        end
        step();
        alloc_ready_i = 1'b1;
        #1;
        n_cmp++; if (plru_access_o !== 1'b1) begin n_err++; $display("FAIL hold_access_pulse: got %b want 1", plru_access_o); end
        n_cmp++; if (plru_way_o !== 4'd5) begin n_err++; $display("FAIL hold_plru_way: got %0d want 5", plru_way_o); end
        n_cmp++; if (meta_set_o !== 8'h34) begin n_err++; $display("FAIL hold_meta_set: got %h want 34", meta_set_o); end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_req_ready_grant: got %b want 0", req_ready_o); end
        step();
        alloc_ready_i = 1'b0;
        #1;
        n_cmp++; if (plru_access_o !== 1'b0) begin n_err++; $display("FAIL hold_access_after: got %b want 0", plru_access_o); end
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_req_ready_after: got %b want 1", req_ready_o); end
    endtask

    task automatic test_invalid_dirty();
        step();
        req_valid_i = 1'b1; req_set_i = 8'hA5; meta_valid_i = 16'hFFF7;
        meta_dirty_i = 16'h0008; plru_victim_i = 4'd3;
        step();
        req_valid_i = 1'b0;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL inv_c1_wb_valid: got %b want 0", wb_valid_o); end
        step();
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL inv_c2_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (alloc_valid_o !== 1'b1) begin n_err++; $display("FAIL inv_alloc_valid: got %b want 1", alloc_valid_o); end
        n_cmp++; if (alloc_way_o !== 4'd3) begin n_err++; $display("FAIL inv_alloc_way: got %0d want 3", alloc_way_o); end
        n_cmp++; if (alloc_evict_o !== 1'b0) begin n_err++; $display("FAIL inv_alloc_evict: got %b want 0", alloc_evict_o); end
        alloc_ready_i = 1'b1;
        step();
        alloc_ready_i = 1'b0;
    endtask

    task automatic test_min_dirty_latency();
        step();
        req_valid_i = 1'b1; req_set_i = 8'h5A; meta_valid_i = 16'hFFFF;
        meta_dirty_i = 16'h8000; plru_victim_i = 4'd15;
        step();
        req_valid_i = 1'b0;
        step();
        wb_ready_i = 1'b1;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b1) begin n_err++; $display("FAIL min_c2_wb_valid: got %b want 1", wb_valid_o); end
        n_cmp++; if (wb_way_o !== 4'd15) begin n_err++; $display("FAIL min_wb_way: got %0d want 15", wb_way_o); end
        step();
        wb_ready_i = 1'b0; wb_done_i = 1'b1;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL min_c3_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL min_c3_alloc: got %b want 0", alloc_valid_o); end
        step();
        wb_done_i = 1'b0;
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b1) begin n_err++; $display("FAIL min_c4_alloc: got %b want 1", alloc_valid_o); end
        n_cmp++; if (alloc_way_o !== 4'd15 || alloc_evict_o !== 1'b1) begin
            n_err++; $display("FAIL min_alloc_fields: got w=%0d e=%b want w=15 e=1", alloc_way_o, alloc_evict_o);
        end
        alloc_ready_i = 1'b1;
        step();
        alloc_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        step();
        req_valid_i = 1'b1; req_set_i = 8'h01; meta_valid_i = 16'hFFFF;
        meta_dirty_i = 16'h0000; plru_victim_i = 4'd2;
        step();
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_c1_ready: got %b want 0", req_ready_o); end
        step();
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b1 || alloc_set_o !== 8'h01) begin
            n_err++; $display("FAIL b2b_first_alloc: got v=%b s=%h want v=1 s=01", alloc_valid_o, alloc_set_o);
        end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_grant_ready: got %b want 0", req_ready_o); end
        alloc_ready_i = 1'b1;
        step();
        alloc_ready_i = 1'b0; req_set_i = 8'h02; plru_victim_i = 4'd7;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_c3_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (meta_set_o !== 8'h02) begin n_err++; $display("FAIL b2b_c3_meta_set: got %h want 02", meta_set_o); end
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_c3_alloc: got %b want 0", alloc_valid_o); end
        step();
        req_valid_i = 1'b0;
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_c4_alloc: got %b want 0", alloc_valid_o); end
        step();
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b1 || alloc_set_o !== 8'h02 || alloc_way_o !== 4'd7) begin
            n_err++; $display("FAIL b2b_second_alloc: got v=%b s=%h w=%0d want v=1 s=02 w=7", alloc_valid_o, alloc_set_o, alloc_way_o);
        end
        alloc_ready_i = 1'b1;
        step();
        alloc_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        req_valid_i = 1'b1; req_set_i = 8'h3C; meta_valid_i = 16'hFFFF;
        meta_dirty_i = 16'h0002; plru_victim_i = 4'd1;
        step();
        req_valid_i = 1'b0;
        step();
        wb_ready_i = 1'b1;
        step();
        wb_ready_i = 1'b0;
        #1;
        n_cmp++; if (wb_valid_o !== 1'b0 || alloc_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rmid_in_wait: got wb=%b alloc=%b want 0 0", wb_valid_o, alloc_valid_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_wb_valid: got %b want 0", wb_valid_o); end
        n_cmp++; if (alloc_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_alloc_valid: got %b want 0", alloc_valid_o); end
        n_cmp++; if (plru_access_o !== 1'b0) begin n_err++; $display("FAIL rmid_access: got %b want 0", plru_access_o); end
        n_cmp++; if (wb_set_o !== 8'h00 || wb_way_o !== 4'd0 || alloc_evict_o !== 1'b0) begin
            n_err++; $display("FAIL rmid_regs: got set=%h way=%0d evict=%b want 00 0 0", wb_set_o, wb_way_o, alloc_evict_o);
        end
        #2;
        rst_ni = 1'b1;
        step();
        wb_done_i = 1'b1;
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_err++; $display("FAIL rmid_done_c0: got alloc=%b ready=%b want 0 1", alloc_valid_o, req_ready_o);
        end
        step();
        wb_done_i = 1'b0;
        #1;
        n_cmp++; if (alloc_valid_o !== 1'b0 || wb_valid_o !== 1'b0 || plru_access_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_err++; $display("FAIL rmid_done_c1: got alloc=%b wb=%b acc=%b ready=%b want 0 0 0 1",
                              alloc_valid_o, wb_valid_o, plru_access_o, req_ready_o);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_set_i     = 8'h00;
        meta_valid_i  = 16'h0000;
        meta_dirty_i  = 16'h0000;
        plru_victim_i = 4'd0;
        wb_ready_i    = 1'b0;
        wb_done_i     = 1'b0;
        alloc_ready_i = 1'b0;

        test_reset();
        test_clean_victim();
        test_dirty_writeback();
        test_invalid_dirty();
        test_min_dirty_latency();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
